// File: rtl/vdc_video_timing_if.sv
// Timing register inputs and raster position/strobe outputs of the VDC timing generator.
interface vdc_video_timing_if;
  logic [7:0] reg_ht, reg_hd, reg_hp, reg_vt, reg_vd, reg_vp;
  logic [4:0] reg_va, reg_ctv;
  logic [3:0] reg_hw, reg_vw, reg_cth;
  logic       reg_im;

  logic [1:0] newFrame;
  logic       newLine, newRow, newCol, endCol, vVisible, hVisible;
  logic [7:0] row, col;
  logic [4:0] line;
  logic       hsync, vsync;

  modport master (
    output reg_ht, reg_hd, reg_hp, reg_hw, reg_vt, reg_va, reg_vd, reg_vp, reg_vw,
           reg_ctv, reg_cth, reg_im,
    input  newFrame, newLine, newRow, newCol, endCol, vVisible, hVisible,
           row, col, line, hsync, vsync
  );
  modport slave (
    input  reg_ht, reg_hd, reg_hp, reg_hw, reg_vt, reg_va, reg_vd, reg_vp, reg_vw,
           reg_ctv, reg_cth, reg_im,
    output newFrame, newLine, newRow, newCol, endCol, vVisible, hVisible,
           row, col, line, hsync, vsync
  );
endinterface

// File: rtl/vdc_video_timing.sv
// C128 VDC raster timing: pixel/column/scanline/row/field counters plus hsync/vsync.
module vdc_video_timing (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable0,
  input  logic              enable1,
  vdc_video_timing_if.slave vif
);
  typedef enum logic {ACTIVE = 1'b0, ADJUST = 1'b1} phase_t;

  logic [3:0] r_pix, w_pix_nxt;
  logic [7:0] r_col, w_col_nxt;
  logic [4:0] r_line, w_line_nxt;
  logic [7:0] r_row, w_row_nxt;
  phase_t     r_phase, w_phase_nxt;
  logic       r_field, w_field_nxt;
  logic [3:0] r_hcnt, w_hcnt_nxt, r_vcnt, w_vcnt_nxt;
  logic       r_hsync, w_hsync_nxt, r_vsync, w_vsync_nxt;
  logic       w_col_adv, w_line_adv, w_end_frame;
  logic       w_new_col, w_new_line, w_new_row;

  // enable0 only marks the first half of a pixel; nothing here advances on it
  logic w_unused;
  assign w_unused = enable0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pix   <= '0;
      r_col   <= '0;
      r_line  <= '0;
      r_row   <= '0;
      r_phase <= ACTIVE;
      r_field <= 1'b0;
      r_hcnt  <= '0;
      r_vcnt  <= '0;
      r_hsync <= 1'b0;
      r_vsync <= 1'b0;
    end else begin
      r_pix   <= w_pix_nxt;
      r_col   <= w_col_nxt;
      r_line  <= w_line_nxt;
      r_row   <= w_row_nxt;
      r_phase <= w_phase_nxt;
      r_field <= w_field_nxt;
      r_hcnt  <= w_hcnt_nxt;
      r_vcnt  <= w_vcnt_nxt;
      r_hsync <= w_hsync_nxt;
      r_vsync <= w_vsync_nxt;
    end
  end

  // All wrap tests use >= so a register shrinking mid-count wraps at once
  always_comb begin
    w_pix_nxt   = r_pix;
    w_col_nxt   = r_col;
    w_line_nxt  = r_line;
    w_row_nxt   = r_row;
    w_phase_nxt = r_phase;
    w_field_nxt = r_field;
    w_hcnt_nxt  = r_hcnt;
    w_vcnt_nxt  = r_vcnt;
    w_hsync_nxt = r_hsync;
    w_vsync_nxt = r_vsync;
    w_end_frame = 1'b0;
    w_col_adv   = enable1 && (r_pix >= vif.reg_cth);
    w_line_adv  = w_col_adv && (r_col >= vif.reg_ht);

    if (enable1)
      w_pix_nxt = w_col_adv ? 4'd0 : r_pix + 4'd1;
    if (w_col_adv)
      w_col_nxt = (r_col >= vif.reg_ht) ? 8'd0 : r_col + 8'd1;

    if (w_line_adv) begin
      if (r_phase == ACTIVE) begin
        if (r_line >= vif.reg_ctv) begin
          w_line_nxt = 5'd0;
          if (r_row >= vif.reg_vt) begin
            if (vif.reg_va == 5'd0) begin
              w_end_frame = 1'b1;
            end else begin
              w_phase_nxt = ADJUST;
              w_row_nxt   = vif.reg_vt + 8'd1;
            end
          end else begin
            w_row_nxt = r_row + 8'd1;
          end
        end else begin
          w_line_nxt = r_line + 5'd1;
        end
      end else begin
        // line+1 >= va, widened so va written to 0 mid-adjust ends the frame
        if (({1'b0, r_line} + 6'd1) >= {1'b0, vif.reg_va})
          w_end_frame = 1'b1;
        else
          w_line_nxt = r_line + 5'd1;
      end
      if (w_end_frame) begin
        w_row_nxt   = 8'd0;
        w_line_nxt  = 5'd0;
        w_phase_nxt = ACTIVE;
        w_field_nxt = vif.reg_im ? ~r_field : 1'b0;
      end
    end

    // Width 0 loads 0; the wrap to 15 on the next advance yields 16 units
    if (w_col_adv) begin
      if (w_col_nxt == vif.reg_hp) begin
        w_hsync_nxt = 1'b1;
        w_hcnt_nxt  = vif.reg_hw;
      end else if (r_hsync) begin
        if (r_hcnt == 4'd1) begin
          w_hsync_nxt = 1'b0;
          w_hcnt_nxt  = 4'd0;
        end else begin
          w_hcnt_nxt = r_hcnt - 4'd1;
        end
      end
    end

    if (w_line_adv) begin
      if (w_row_nxt == vif.reg_vp && w_line_nxt == 5'd0 && w_phase_nxt == ACTIVE) begin
        w_vsync_nxt = 1'b1;
        w_vcnt_nxt  = vif.reg_vw;
      end else if (r_vsync) begin
        if (r_vcnt == 4'd1) begin
          w_vsync_nxt = 1'b0;
          w_vcnt_nxt  = 4'd0;
        end else begin
          w_vcnt_nxt = r_vcnt - 4'd1;
        end
      end
    end
  end

  assign w_new_col  = (r_pix == 4'd0);
  assign w_new_line = (r_col == 8'd0) && w_new_col;
  assign w_new_row  = w_new_line && (r_line == 5'd0) && (r_phase == ACTIVE);

  assign vif.newCol   = w_new_col;
  assign vif.endCol   = (r_pix >= vif.reg_cth);
  assign vif.newLine  = w_new_line;
  assign vif.newRow   = w_new_row;
  assign vif.newFrame = (w_new_row && r_row == 8'd0) ?
                        (vif.reg_im ? (r_field ? 2'b01 : 2'b10) : 2'b11) : 2'b00;
  assign vif.vVisible = (r_phase == ACTIVE) && (r_row < vif.reg_vd);
  assign vif.hVisible = (r_col < vif.reg_hd);
  assign vif.row      = r_row;
  assign vif.col      = r_col;
  assign vif.line     = r_line;
  assign vif.hsync    = r_hsync;
  assign vif.vsync    = r_vsync;
endmodule

// File: doc/vdc_video_timing.md
# vdc_video_timing

Character-based raster timing generator for the C128 VDC. It runs the pixel, column, scanline, row and field counters from the CRTC timing registers. It drives the position and strobe signals (newFrame, newLine, newRow, newCol, endCol, vVisible, row, col, line) consumed by the VDC RAM interface and pixel stages. It also drives hsync/vsync to the video output.

## Interface
Parameters: none.

Ports:
- clk  in  1  system clock; one clock for the whole block
- reset  in  1  synchronous, active-high
- enable0  in  1  first-half pixel strobe; timing never advances on it
- enable1  in  1  pixel tick; every counter advances only on it
- reg_ht  in  8  horizontal total, minus 1 (chars)
- reg_hd  in  8  horizontal displayed (chars)
- reg_hp  in  8  hsync start column
- reg_hw  in  4  hsync width (chars; 0 = 16)
- reg_vt  in  8  vertical total, minus 1 (rows)
- reg_va  in  5  vertical adjust (scanlines)
- reg_vd  in  8  vertical displayed (rows)
- reg_vp  in  8  vsync start row
- reg_vw  in  4  vsync width (scanlines; 0 = 16)
- reg_ctv  in  5  character total vertical, minus 1
- reg_cth  in  4  character total horizontal, minus 1 (pixels)
- reg_im  in  1  interlace enable
- newFrame  out  2  11 = new frame (non-interlaced), 10 = even field, 01 = odd field, 00 = none
- newLine  out  1  first column of a scanline
- newRow  out  1  first column of line 0 of a character row
- newCol  out  1  first pixel of a column
- endCol  out  1  last pixel of a column
- vVisible  out  1  current row is a displayed row
- hVisible  out  1  current column is displayed
- row  out  8  current row
- col  out  8  current column
- line  out  5  scanline within row or adjust area
- hsync  out  1  active-high horizontal sync
- vsync  out  1  active-high vertical sync

## Operation
- Registered state:
  - pix[3:0], col[7:0], line[4:0], row[7:0]
  - phase (ACTIVE / ADJUST)
  - field, hcnt[3:0], vcnt[3:0], hsync, vsync
- All outputs except hsync/vsync are combinational decodes of registered state.
- Pixel counter:
  - On enable1: if pix >= reg_cth then pix <= 0 and advance column; else pix++.
  - Compare with >= everywhere, so a register shrinking mid-count cannot cause a runaway.
- Column:
  - If col >= reg_ht then col <= 0 and advance scanline; else col++.
- Scanline, ACTIVE phase:
  - If line >= reg_ctv then line <= 0 and advance row; else line++.
  - Row advance: if row >= reg_vt then:
    - reg_va == 0: end frame.
    - else: phase <= ADJUST, line <= 0, row <= reg_vt+1 (8-bit wrap).
  - Otherwise row++.
- Scanline, ADJUST phase:
  - If line >= reg_va-1 then end frame; else line++.
- End frame:
  - row <= 0, line <= 0, phase <= ACTIVE.
  - field <= reg_im ? ~field : 0.
- Decodes:
  - newCol = (pix == 0)
  - endCol = (pix >= reg_cth)
  - newLine = (col == 0) && newCol
  - newRow = newLine && line == 0 && phase == ACTIVE
  - newFrame = (newRow && row == 0) ? (reg_im ? (field ? 01 : 10) : 11) : 00
  - vVisible = phase == ACTIVE && row < reg_vd
  - hVisible = col < reg_hd
- hsync:
  - On the pixel tick entering column reg_hp (pix wrap): hsync <= 1, hcnt <= reg_hw.
  - At each further column advance: hcnt--.
  - When hcnt reaches 1 at a column advance: hsync <= 0.
  - reg_hw == 0 counts as 16 columns.
- vsync:
  - On the scanline advance entering row reg_vp, line 0, ACTIVE: vsync <= 1, vcnt <= reg_vw.
  - Counts scanlines the same way as hsync counts columns; 0 = 16.
  - vsync continues counting across end of frame.

## Timing
- Reset state:
  - pix = col = line = row = 0; phase = ACTIVE; field = 0.
  - hsync = vsync = 0; hcnt = vcnt = 0.
  - Therefore after reset: newCol = newLine = newRow = 1, newFrame = 11 (or 10 if reg_im), endCol = (reg_cth == 0).
- Latency:
  - State changes one clk after an enable1 strobe.
  - enable0 never changes state, so strobes are stable across the enable0 … enable1 pair of a pixel.
  - Consumers sample newCol with enable0 and endCol with enable1.
- reg_cth == 0: newCol and endCol are both high for the same single pixel.
- All counters stall when enable1 is low.
- Reset mid-frame: returns to the reset state on the next clk, regardless of enables.
- Register writes take effect at the next comparison; no shadowing.

## Test plan
- Reset, then enable1 every clk with cth=7, ht=9, ctv=7, vt=3, va=0 -> newCol every 8 ticks, newLine every 80 ticks, newRow every 640, newFrame=11 every 2560 ticks; col 0..9, line 0..7, row 0..3.
- Same with va=3 -> after row 3 line 7, three lines with row=4, phase ADJUST, vVisible=0, newRow=0, newLine=1; frame period 2800 ticks.
- reg_im=1 -> successive frame starts show newFrame 10, 01, 10; reg_im=0 mid-run forces 11 from next frame.
- hp=5, hw=2 -> hsync high exactly for cols 5–6 each line. hw=0 -> 16 columns, wrapping past ht. vp=2, vw=3 -> vsync high for row 2 lines 0–2.
- With col=9, write ht=4 -> next column advance wraps col to 0 (no count to 255).
- enable1 held low 100 clks mid-line -> all outputs frozen. Assert reset at row 2 col 5 -> next clk all counters 0, newFrame=11.
